spi_sram_target: RTL and testbench

SPI target that emulates a 16-bit-address serial SRAM: it decodes the READ (0x03) / WRITE (0x02) command, address and data bytes sent by the SPI SRAM master, and executes them against an on-chip byte-wide synchronous memory port. It sits on the far end of the SPI link from the CPU's memory controller. It serves as the on-die memory responder and as the bench model for the master. SCLK, CS and MOSI are asynchronous to `clk` and are oversampled.

---
 rtl/spi_sram_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_sram_target.sv | 217 +++++++++++++++++++++
 tb/tb_spi_sram_target.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI serial-SRAM target and its master: command codes,
// protocol state encoding and field-length helper.
package spi_sram_pkg;

  localparam logic [7:0] READ_COMMAND    = 8'h03;
  localparam logic [7:0] WRITE_COMMAND   = 8'h02;
  localparam int         ADDR_FIELD_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } spi_state_t;

  // Index of the first (MSB) bit of the field shifted while in the given state.
  function automatic logic [4:0] field_last_bit(input spi_state_t s);
    return (s == ADDR) ? 5'(ADDR_FIELD_BITS - 1) : 5'd7;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, followed by registered
// rise/fall strobes that are one clk wide.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;

  // Reset to low so a pin that is already low at reset release never yields a fall strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 target emulating a 16-bit-address serial SRAM on a byte-wide memory port.
// Define SPI_SRAM_SEQ_EN for sequential (auto-increment) access; otherwise one byte per frame.
module spi_sram_target
  import spi_sram_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 cmd_err
);

`ifdef SPI_SRAM_SEQ_EN
  localparam bit SEQ_MODE = 1'b1;
`else
  localparam bit SEQ_MODE = 1'b0;
`endif

  spi_state_t state, state_next;

  logic                 sclk_rise, sclk_fall;
  logic                 cs_rise, cs_fall;
  logic [SYNC_STAGES:0] mosi_q;
  logic                 mosi_s;
  logic [4:0]           bit_cnt;
  logic [14:0]          in_shreg;
  logic [15:0]          in_next;
  logic                 field_done;
  logic                 read_op;
  logic                 first_byte;
  logic                 re_d;
  logic [7:0]           out_shreg;
  logic [7:0]           rbuf;
  logic                 cmd_read, cmd_write, cmd_bad;
  logic                 addr_done, byte_done;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // One extra stage keeps MOSI aligned with the registered SCLK strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-1:0], mosi};
    end
  end

  assign mosi_s     = mosi_q[SYNC_STAGES];
  assign in_next    = {in_shreg, mosi_s};
  assign field_done = sclk_rise && (bit_cnt == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_read   = 1'b0;
    cmd_write  = 1'b0;
    cmd_bad    = 1'b0;
    addr_done  = 1'b0;
    byte_done  = 1'b0;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) state_next = CMD;
        end
        CMD: begin
          if (field_done) begin
            if (in_next[7:0] == READ_COMMAND) begin
              cmd_read   = 1'b1;
              state_next = ADDR;
            end else if (in_next[7:0] == WRITE_COMMAND) begin
              cmd_write  = 1'b1;
              state_next = ADDR;
            end else begin
              cmd_bad    = 1'b1;
              state_next = IGNORE;
            end
          end
        end
        ADDR: begin
          if (field_done) begin
            addr_done  = 1'b1;
            state_next = read_op ? RDATA : WDATA;
          end
        end
        WDATA, RDATA: begin
          if (field_done) begin
            byte_done = 1'b1;
            if (!SEQ_MODE) state_next = IGNORE;
          end
        end
        IGNORE: begin
          state_next = IGNORE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      in_shreg   <= '0;
      read_op    <= 1'b0;
      first_byte <= 1'b0;
      re_d       <= 1'b0;
      out_shreg  <= '0;
      rbuf       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      cmd_err <= cmd_bad;
      re_d    <= mem_re;

      if (state == IDLE && cs_fall) begin
        bit_cnt    <= field_last_bit(CMD);
        first_byte <= 1'b1;
      end

      if (!cs_rise && sclk_rise && (state inside {CMD, ADDR, WDATA, RDATA})) begin
        bit_cnt  <= field_done ? field_last_bit(state_next) : bit_cnt - 5'd1;
        in_shreg <= in_next[14:0];
      end

      if (cmd_read)  read_op <= 1'b1;
      if (cmd_write) read_op <= 1'b0;

      if (addr_done) begin
        mem_addr <= in_next[ADDR_BITS-1:0];
        mem_re   <= read_op;
      end

      if (byte_done && state == WDATA) begin
        mem_wdata <= in_next[7:0];
        mem_we    <= 1'b1;
      end

      // Sequential writes advance the address once the strobe for the current byte is out.
      if (SEQ_MODE && mem_we && state == WDATA) begin
        mem_addr <= mem_addr + ADDR_BITS'(1);
      end

      if (SEQ_MODE && byte_done && state == RDATA) begin
        mem_addr   <= mem_addr + ADDR_BITS'(1);
        mem_re     <= 1'b1;
        first_byte <= 1'b0;
      end

      // Follow-on read bytes wait in rbuf until the falling edge that starts their first bit.
      if (state == RDATA && !cs_rise) begin
        if (re_d) begin
          if (first_byte) out_shreg <= mem_rdata;
          else            rbuf      <= mem_rdata;
        end
        if (sclk_fall) begin
          if (bit_cnt != field_last_bit(RDATA)) out_shreg <= {out_shreg[6:0], 1'b0};
          else if (!first_byte)                 out_shreg <= rbuf;
        end
      end

      if (cs_rise) begin
        in_shreg  <= '0;
        out_shreg <= '0;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign miso_oe = (state == RDATA);
  assign miso    = miso_oe & out_shreg[7];

endmodule

// File: tb/tb_spi_sram_target.sv
// Self-checking bench for spi_sram_target: SPI master stimulus, memory model and
// scoreboards for memory accesses and bytes returned on MISO.
module tb_spi_sram_target;
  import spi_sram_pkg::*;

  localparam int ADDR_BITS   = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 50;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } op_t;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 sclk  = 1'b0;
  logic                 cs    = 1'b1;
  logic                 mosi  = 1'b0;
  logic                 miso, miso_oe, mem_we, mem_re, busy, cmd_err;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata = 8'h00;

  logic [7:0] mem_model [0:65535];
  op_t        op_q[$];
  logic [7:0] rx_q[$];

  int checks        = 0;
  int failures      = 0;
  int cmd_err_count = 0;
  int oe_cycles     = 0;
  int access_count  = 0;

  spi_sram_target #(
    .ADDR_BITS  (ADDR_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  function automatic logic [31:0] outs();
    return {2'b00, miso, miso_oe, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err};
  endfunction

  // Synchronous memory: write on mem_we, read data valid one clk after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= mem_model[mem_addr];
  end

  // Access monitor pops the scoreboard whenever the DUT strobes the memory port.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_err) cmd_err_count++;
      if (miso_oe) oe_cycles++;
      if (mem_we || mem_re) begin
        op_t e;
        access_count++;
        checkOutput("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
        checkOutput("access_expected", 32'(op_q.size() > 0), 32'd1);
        if (op_q.size() > 0) begin
          e = op_q.pop_front();
          checkOutput("mem_access", {7'd0, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00},
                      {7'd0, e.we, e.addr, e.we ? e.data : 8'h00});
        end
      end
    end
  end

  task automatic syncClk();
    @(posedge clk);
    #2;
  endtask

  // One mode-0 byte: MOSI changes with SCLK low, MISO and its enable are sampled at each rise.
  task automatic applyStimulus(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #HALF;
      sclk  = 1'b1;
      rx[i] = miso;
      oe[i] = miso_oe;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic startFrame();
    cs = 1'b0;
    #HALF;
  endtask

  task automatic endFrame();
    #HALF;
    cs = 1'b1;
    #(4 * HALF);
  endtask

  task automatic sendHeader(input logic [7:0] cmd, input logic [15:0] addr, output logic [7:0] oe_all);
    logic [7:0] rx, oe;
    applyStimulus(cmd, rx, oe);
    oe_all = oe;
    applyStimulus(addr[15:8], rx, oe);
    oe_all = oe_all | oe;
    applyStimulus(addr[7:0], rx, oe);
    oe_all = oe_all | oe;
  endtask

  initial begin
    logic [7:0] rx, oe, hdr_oe;
    int n, waited;

    #2 rst_n = 1'b0;
    syncClk();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    #100;
    checkOutput("idle_after_reset", outs(), 32'd0);

    // Single byte write
    oe_cycles = 0;
    n = cmd_err_count;
    op_q.push_back(op_t'{we: 1'b1, addr: 16'h1234, data: 8'hA5});
    startFrame();
    sendHeader(WRITE_COMMAND, 16'h1234, hdr_oe);
    applyStimulus(8'hA5, rx, oe);
    endFrame();
    checkOutput("write_ops_done", 32'(op_q.size()), 32'd0);
    checkOutput("write_miso_oe_cycles", 32'(oe_cycles), 32'd0);
    checkOutput("write_no_cmd_err", 32'(cmd_err_count - n), 32'd0);
    checkOutput("write_busy_after", 32'(busy), 32'd0);

    // Single byte read
    mem_model[16'h00FF] = 8'h3C;
    op_q.push_back(op_t'{we: 1'b0, addr: 16'h00FF, data: 8'h00});
    rx_q.push_back(8'h3C);
    startFrame();
    sendHeader(READ_COMMAND, 16'h00FF, hdr_oe);
    checkOutput("read_header_oe", 32'(hdr_oe), 32'd0);
    applyStimulus(8'h00, rx, oe);
    checkOutput("read_data", 32'(rx), 32'(rx_q.pop_front()));
    checkOutput("read_data_oe", 32'(oe), 32'h0000_00FF);
    endFrame();
    checkOutput("read_oe_after_cs", 32'(miso_oe), 32'd0);
    checkOutput("read_ops_done", 32'(op_q.size()), 32'd0);

    // Unsupported command followed by 24 more clocks
    n = cmd_err_count;
    waited = access_count;
    startFrame();
    applyStimulus(8'h05, rx, oe);
    hdr_oe = oe;
    for (int b = 0; b < 3; b++) begin
      applyStimulus(8'h03, rx, oe);
      hdr_oe = hdr_oe | oe;
    end
    checkOutput("bad_no_oe", 32'(hdr_oe), 32'd0);
    checkOutput("bad_no_access", 32'(access_count - waited), 32'd0);
    #HALF;
    checkOutput("bad_busy_before_cs", 32'(busy), 32'd1);
    cs = 1'b1;
    waited = 0;
    while (busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("bad_busy_drop_bounded", 32'(waited <= SYNC_STAGES + 3), 32'd1);
    syncClk();
    #(4 * HALF);
    checkOutput("bad_cmd_err_pulses", 32'(cmd_err_count - n), 32'd1);

    // Aborted write leaves the old value in place
    op_q.push_back(op_t'{we: 1'b1, addr: 16'h0040, data: 8'h5A});
    startFrame();
    sendHeader(WRITE_COMMAND, 16'h0040, hdr_oe);
    applyStimulus(8'h5A, rx, oe);
    endFrame();
    n = access_count;
    startFrame();
    sendHeader(WRITE_COMMAND, 16'h0040, hdr_oe);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    endFrame();
    checkOutput("abort_no_write", 32'(access_count - n), 32'd0);
    op_q.push_back(op_t'{we: 1'b0, addr: 16'h0040, data: 8'h00});
    rx_q.push_back(8'h5A);
    startFrame();
    sendHeader(READ_COMMAND, 16'h0040, hdr_oe);
    applyStimulus(8'h00, rx, oe);
    endFrame();
    checkOutput("abort_readback", 32'(rx), 32'(rx_q.pop_front()));

    // Two data bytes at the top of the address space in one frame
`ifdef SPI_SRAM_SEQ_EN
    op_q.push_back(op_t'{we: 1'b1, addr: 16'hFFFF, data: 8'h11});
    op_q.push_back(op_t'{we: 1'b1, addr: 16'h0000, data: 8'h22});
`else
    op_q.push_back(op_t'{we: 1'b1, addr: 16'hFFFF, data: 8'h11});
`endif
    startFrame();
    sendHeader(WRITE_COMMAND, 16'hFFFF, hdr_oe);
    applyStimulus(8'h11, rx, oe);
    applyStimulus(8'h22, rx, oe);
    endFrame();
    checkOutput("cfg_write_ops_done", 32'(op_q.size()), 32'd0);

`ifdef SPI_SRAM_SEQ_EN
    op_q.push_back(op_t'{we: 1'b0, addr: 16'hFFFF, data: 8'h00});
    op_q.push_back(op_t'{we: 1'b0, addr: 16'h0000, data: 8'h00});
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
`else
    op_q.push_back(op_t'{we: 1'b0, addr: 16'hFFFF, data: 8'h00});
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h00);
`endif
    startFrame();
    sendHeader(READ_COMMAND, 16'hFFFF, hdr_oe);
    applyStimulus(8'h00, rx, oe);
    checkOutput("cfg_read_byte0", 32'(rx), 32'(rx_q.pop_front()));
    applyStimulus(8'h00, rx, oe);
    checkOutput("cfg_read_byte1", 32'(rx), 32'(rx_q.pop_front()));
    endFrame();
    checkOutput("cfg_read_ops_done", 32'(op_q.size()), 32'd0);

    // Reset in the middle of a read byte, then a fresh read
    mem_model[16'h0200] = 8'hC3;
    op_q.push_back(op_t'{we: 1'b0, addr: 16'h0200, data: 8'h00});
    startFrame();
    sendHeader(READ_COMMAND, 16'h0200, hdr_oe);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b0;
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    #20;
    checkOutput("rst_oe_before", 32'(miso_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_read_outputs", outs(), 32'd0);
    #9;
    cs = 1'b1;
    #100;
    rst_n = 1'b1;
    #100;
    op_q.push_back(op_t'{we: 1'b0, addr: 16'h0200, data: 8'h00});
    rx_q.push_back(8'hC3);
    startFrame();
    sendHeader(READ_COMMAND, 16'h0200, hdr_oe);
    applyStimulus(8'h00, rx, oe);
    endFrame();
    checkOutput("rst_fresh_read", 32'(rx), 32'(rx_q.pop_front()));
    checkOutput("all_ops_consumed", 32'(op_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
